// File: rtl/eject_ni_rx.sv
// Local-port NI receiver: checks packet heads from the router Eject port, buffers payload
// words in a small FIFO for the core and returns credits. Optional macro: TRUST_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a packet head
// RECV  | accepted packet in progress, body/tail flits are buffered
// DROP  | rejected packet in progress, flits are discarded
module eject_ni_rx #(
  parameter logic [2:0] MY_X      = 3'd0,
  parameter logic [2:0] MY_Y      = 3'd0,
  parameter int         DEPTH     = 8,
  parameter logic [3:0] TRUST_MIN = 4'd8
) (
  input  logic         clk1,
  input  logic         reset,
  input  logic [127:0] flit_in,
  input  logic         flit_vld,
  output logic         credit,
  output logic [99:0]  pl_out,
  output logic         pl_vld,
  output logic         pl_last,
  input  logic         pl_rdy,
  output logic [7:0]   pkt_src,
  output logic         pkt_done,
  output logic         pkt_err,
  output logic [1:0]   err_code,
  output logic [3:0]   occ
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [2:0] PTR_MAX = 3'(DEPTH - 1);

  state_t       state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic [7:0]   src_nxt;
  logic [100:0] mem [DEPTH];
  logic [2:0]   rd_ptr, wr_ptr;
  logic [3:0]   owed, owed_nxt, credit_sum;
  logic         push, push_last, pop, discard, full, take;
  logic         err_nxt, credit_nxt;
  logic [1:0]   code_nxt;
  logic         dst_ok, len_ok, trust_ok;

  wire [2:0]  f_dst_x = flit_in[127:125];
  wire [2:0]  f_dst_y = flit_in[124:122];
  wire [7:0]  f_src   = flit_in[121:114];
  wire [7:0]  f_len   = flit_in[113:106];
  wire [1:0]  f_type  = flit_in[5:4];
  wire        is_head = f_type[0];
  wire        is_tail = f_type[1];

  assign dst_ok = (f_dst_x == MY_X) && (f_dst_y == MY_Y);
  assign len_ok = is_tail ? (f_len == 8'd0) : (f_len != 8'd0);
`ifdef TRUST_CHECK_EN
  assign trust_ok = (flit_in[3:0] >= TRUST_MIN);
`else
  logic trust_unused;
  assign trust_unused = ^{flit_in[3:0], TRUST_MIN};
  assign trust_ok = 1'b1;
`endif

  assign full     = (occ == DEPTH_C);
  assign take     = flit_vld & ~full;
  assign pl_vld   = (occ != 4'd0);
  assign pop      = pl_vld & pl_rdy;
  assign pl_out   = pl_vld ? mem[rd_ptr][99:0] : '0;
  assign pl_last  = pl_vld & mem[rd_ptr][100];
  assign pkt_done = pop & pl_last;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = pkt_src;
    push      = 1'b0;
    push_last = 1'b0;
    discard   = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    if (flit_vld && full) begin
      // Router overran our credits: drop silently except for the error report.
      err_nxt  = 1'b1;
      code_nxt = 2'b10;
    end else if (take) begin
      unique case (state)
        IDLE: begin
          if (is_head) begin
            cnt_nxt = f_len;
            if (!dst_ok) begin
              discard = 1'b1; err_nxt = 1'b1; code_nxt = 2'b01;
            end else if (!len_ok) begin
              discard = 1'b1; err_nxt = 1'b1; code_nxt = 2'b10;
            end else if (!trust_ok) begin
              discard = 1'b1; err_nxt = 1'b1; code_nxt = 2'b11;
            end else begin
              push      = 1'b1;
              push_last = is_tail;
              src_nxt   = f_src;
              if (!is_tail) state_nxt = RECV;
            end
            if (discard && !is_tail && f_len != 8'd0) state_nxt = DROP;
          end else begin
            discard = 1'b1; err_nxt = 1'b1; code_nxt = 2'b10;
          end
        end
        RECV: begin
          if (is_head) begin
            discard = 1'b1; err_nxt = 1'b1; code_nxt = 2'b10;
          end else begin
            push    = 1'b1;
            cnt_nxt = cnt - 8'd1;
            if (is_tail || cnt <= 8'd1) begin
              push_last = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        DROP: begin
          discard = 1'b1;
          cnt_nxt = cnt - 8'd1;
          if (is_tail || cnt <= 8'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pops and discards can coincide; surplus credits queue up and drain one per cycle.
  assign credit_sum = {3'b000, pop} + {3'b000, discard} + owed;
  assign credit_nxt = (credit_sum != 4'd0);
  assign owed_nxt   = credit_sum - {3'b000, credit_nxt};

  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= {push_last, flit_in[105:6]};
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      owed     <= '0;
      credit   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 2'b00;
      pkt_src  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      owed     <= owed_nxt;
      credit   <= credit_nxt;
      pkt_err  <= err_nxt;
      err_code <= code_nxt;
      pkt_src  <= src_nxt;
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? 3'd0 : wr_ptr + 3'd1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? 3'd0 : rd_ptr + 3'd1;
      if (push && !pop)      occ <= occ + 4'd1;
      else if (!push && pop) occ <= occ - 4'd1;
    end
  end

endmodule

// File: tb/tb_eject_ni_rx.sv
// Directed bench for eject_ni_rx: acceptance, drops, full-FIFO overrun, credit merging
// and reset flush; the trust cases run only when TRUST_CHECK_EN is defined.
module tb_eject_ni_rx;
  logic         clk1 = 1'b0;
  logic         reset;
  logic [127:0] flit_in;
  logic         flit_vld;
  logic         credit;
  logic [99:0]  pl_out;
  logic         pl_vld;
  logic         pl_last;
  logic         pl_rdy;
  logic [7:0]   pkt_src;
  logic         pkt_done;
  logic         pkt_err;
  logic [1:0]   err_code;
  logic [3:0]   occ;

  int total = 0;
  int bad   = 0;
  int n_credit = 0, n_vld = 0, n_done = 0;
  int c0, v0, d0;

  eject_ni_rx dut (
    .clk1(clk1), .reset(reset), .flit_in(flit_in), .flit_vld(flit_vld),
    .credit(credit), .pl_out(pl_out), .pl_vld(pl_vld), .pl_last(pl_last),
    .pl_rdy(pl_rdy), .pkt_src(pkt_src), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .err_code(err_code), .occ(occ)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (credit)   n_credit++;
    if (pl_vld)   n_vld++;
    if (pkt_done) n_done++;
  end

  function automatic logic [127:0] mk(input logic [2:0] dx, input logic [2:0] dy,
                                      input logic [7:0] src, input logic [7:0] len,
                                      input logic [99:0] pl, input logic [1:0] typ,
                                      input logic [3:0] trust);
    return {dx, dy, src, len, pl, typ, trust};
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flit_vld = 1'b0; flit_in = '0; pl_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_occ", occ, 0);
    chk("rst_vld", pl_vld, 0);
    chk("rst_out", pl_out, 0);
    chk("rst_credit", credit, 0);
    chk("rst_err", {pkt_err, err_code}, 0);
    chk("rst_src", pkt_src, 0);
    reset = 1'b0;
    tick();

    // Accepted three-flit packet streamed straight through
    c0 = n_credit;
    pl_rdy = 1'b1; flit_vld = 1'b1;
    flit_in = mk(3'd0, 3'd0, 8'h5A, 8'd2, 100'hAB, 2'b01, 4'd0);
    tick();
    chk("t1_vld", pl_vld, 1);
    chk("t1_w0", pl_out, 100'hAB);
    chk("t1_occ", occ, 1);
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'h1E, 2'b00, 4'd0);
    tick();
    chk("t1_w1", pl_out, 100'h1E);
    chk("t1_last1", pl_last, 0);
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'hF, 2'b10, 4'd0);
    tick();
    chk("t1_w2", pl_out, 100'hF);
    chk("t1_last2", pl_last, 1);
    chk("t1_done", pkt_done, 1);
    chk("t1_src", pkt_src, 8'h5A);
    flit_vld = 1'b0;
    tick();
    chk("t1_occ_end", occ, 0);
    chk("t1_done_end", pkt_done, 0);
    repeat (2) tick();
    chk("t1_credits", n_credit - c0, 3);

    // Wrong destination: whole packet dropped
    c0 = n_credit; v0 = n_vld;
    flit_vld = 1'b1;
    flit_in = mk(3'd7, 3'd7, 8'h33, 8'd4, 100'h1, 2'b01, 4'd0);
    tick();
    chk("t2_err", pkt_err, 1);
    chk("t2_code", err_code, 2'b01);
    for (int i = 0; i < 4; i++) begin
      flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'(i), (i == 3) ? 2'b10 : 2'b00, 4'd0);
      tick();
      chk("t2_body_noerr", pkt_err, 0);
    end
    flit_vld = 1'b0;
    repeat (3) tick();
    chk("t2_credits", n_credit - c0, 5);
    chk("t2_novld", n_vld - v0, 0);
    chk("t2_code_hold", err_code, 2'b01);

    // Fill the FIFO with the core stalled, then overrun it
    c0 = n_credit;
    pl_rdy = 1'b0; flit_vld = 1'b1;
    flit_in = mk(3'd0, 3'd0, 8'h77, 8'd7, 100'h100, 2'b01, 4'd0);
    tick();
    for (int i = 1; i < 8; i++) begin
      flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'h100 + 100'(i), 2'b00, 4'd0);
      tick();
    end
    chk("t3_full", occ, 8);
    chk("t3_hold", pl_out, 100'h100);
    chk("t3_hold_last", pl_last, 0);
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'h999, 2'b00, 4'd0);
    tick();
    chk("t3_ovr_err", pkt_err, 1);
    chk("t3_ovr_code", err_code, 2'b10);
    chk("t3_ovr_occ", occ, 8);
    flit_vld = 1'b0;
    repeat (2) tick();
    chk("t3_nocredit", n_credit - c0, 0);
    c0 = n_credit; d0 = n_done;
    pl_rdy = 1'b1;
    repeat (3) tick();
    chk("t3_mid_word", pl_out, 100'h103);
    repeat (5) tick();
    chk("t3_drained", occ, 0);
    repeat (2) tick();
    chk("t3_credits", n_credit - c0, 8);
    chk("t3_done", n_done - d0, 1);

    // Body in IDLE, then a pop coinciding with a discard
    pl_rdy = 1'b0; flit_vld = 1'b1;
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'h5, 2'b00, 4'd0);
    tick();
    chk("t4_err", pkt_err, 1);
    chk("t4_code", err_code, 2'b10);
    chk("t4_credit", credit, 1);
    flit_in = mk(3'd0, 3'd0, 8'h21, 8'd0, 100'h44, 2'b11, 4'd0);
    tick();
    chk("t4_ht_occ", occ, 1);
    chk("t4_ht_last", pl_last, 1);
    chk("t4_ht_src", pkt_src, 8'h21);
    chk("t4_ht_noerr", pkt_err, 0);
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'h6, 2'b00, 4'd0);
    pl_rdy = 1'b1;
    #1;
    chk("t4_done", pkt_done, 1);
    tick();
    chk("t4_cr_a", credit, 1);
    chk("t4_err2", pkt_err, 1);
    flit_vld = 1'b0;
    tick();
    chk("t4_cr_b", credit, 1);
    tick();
    chk("t4_cr_c", credit, 0);

`ifdef TRUST_CHECK_EN
    flit_vld = 1'b1;
    flit_in = mk(3'd0, 3'd0, 8'h42, 8'd0, 100'h9, 2'b11, 4'd7);
    tick();
    chk("t5_err", pkt_err, 1);
    chk("t5_code", err_code, 2'b11);
    chk("t5_credit", credit, 1);
    chk("t5_occ", occ, 0);
    flit_in = mk(3'd0, 3'd0, 8'h42, 8'd0, 100'h9, 2'b11, 4'd15);
    tick();
    chk("t5_acc_occ", occ, 1);
    chk("t5_acc_last", pl_last, 1);
    chk("t5_acc_src", pkt_src, 8'h42);
    flit_vld = 1'b0;
    tick();
`endif

    // Reset in the middle of a buffered packet
    pl_rdy = 1'b0; flit_vld = 1'b1;
    flit_in = mk(3'd0, 3'd0, 8'h66, 8'd5, 100'hA0, 2'b01, 4'd0);
    tick();
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'hA1, 2'b00, 4'd0);
    tick();
    flit_in = mk(3'd0, 3'd0, 8'h00, 8'd0, 100'hA2, 2'b00, 4'd0);
    tick();
    flit_vld = 1'b0;
    chk("t6_occ3", occ, 3);
    reset = 1'b1;
    tick();
    chk("t6_occ0", occ, 0);
    chk("t6_vld0", pl_vld, 0);
    chk("t6_credit0", credit, 0);
    chk("t6_src0", pkt_src, 0);
    chk("t6_code0", err_code, 0);
    reset = 1'b0;
    flit_vld = 1'b1;
    flit_in = mk(3'd0, 3'd0, 8'h12, 8'd0, 100'hCC, 2'b11, 4'd0);
    tick();
    chk("t6_idle_occ", occ, 1);
    chk("t6_idle_noerr", pkt_err, 0);
    chk("t6_idle_word", pl_out, 100'hCC);
    flit_vld = 1'b0; pl_rdy = 1'b1;
    tick();
    chk("t6_drain", occ, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
